pipeline_hazard_ctrl: RTL and testbench

//  Hazard and sequencing controller for the 5-stage vector pipeline (F/D/E/M/W, 48-bit lanes).

---
 rtl/pipeline_hazard_ctrl_if.sv | 37 +++
 rtl/pipeline_hazard_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard controller bundle: pipeline status into the controller and
// stall/flush/forward/memory control back out to the datapath.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_AW = 4
);
  logic [REG_AW-1:0] RA1D, RA2D, RA1E, RA2E;
  logic [REG_AW-1:0] WA3E, WA3M, WA3W;
  logic              regWriteE, regWriteM, regWriteW;
  logic              memToRegE, memWriteM, memToRegM;
  logic              PCSrcD, PCSrcE, PCSrcM, PCSrcW;
  logic              branchTakenE;
  logic              mem_ready;
  logic [1:0]        forwardAE, forwardBE;
  logic              stallF, stallD, stallE, stallM;
  logic              flushD, flushE, flushW;
  logic              mem_req, mem_err;

  // Pipeline/datapath side: supplies stage status, consumes controls.
  modport master (
    output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    output regWriteE, regWriteM, regWriteW,
    output memToRegE, memWriteM, memToRegM,
    output PCSrcD, PCSrcE, PCSrcM, PCSrcW, branchTakenE, mem_ready,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, mem_req, mem_err
  );

  // Controller side.
  modport slave (
    input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
    input  regWriteE, regWriteM, regWriteW,
    input  memToRegE, memWriteM, memToRegM,
    input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, branchTakenE, mem_ready,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, mem_req, mem_err
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage vector pipeline.
// Forwarding and stall/flush decisions are combinational; a small FSM
// tracks multi-cycle M-stage memory accesses and latches a sticky
// timeout error when mem_ready never arrives.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 4,
  parameter int MEM_TIMEOUT = 16
) (
  input logic                  clk,
  input logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
);
  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;

  logic mem_op_s, mem_stall_s, ld_stall_s, pc_pend_s;

  assign mem_op_s    = hz.memWriteM || hz.memToRegM;
  // ERR keeps the pipe frozen even if the M-stage op disappears.
  assign mem_stall_s = (mem_op_s && !hz.mem_ready && (state_r != S_ERR)) || (state_r == S_ERR);
  assign ld_stall_s  = hz.memToRegE && ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));
  assign pc_pend_s   = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
  assign hz.mem_err  = (state_r == S_ERR);

  // Memory-wait state and cycle counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Memory-wait next state: a same-cycle completion never leaves IDLE.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      S_IDLE: begin
        if (mem_op_s && !hz.mem_ready) begin
          state_nxt_s = S_WAIT;
          cnt_nxt_s   = CW'(1);
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (hz.mem_ready) begin
          state_nxt_s = S_IDLE;
          cnt_nxt_s   = '0;
        end else if (cnt_r == CNT_LAST) begin
          state_nxt_s = S_ERR;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      S_ERR: begin
        state_nxt_s = S_ERR;
      end
      default: begin
        state_nxt_s = S_IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Forwarding, stall and flush selection; memory stall outranks
  // control/load-use hazards, which simply re-evaluate after release.
  always_comb begin
    hz.forwardAE = 2'b00;
    hz.forwardBE = 2'b00;
    hz.stallF    = 1'b0;
    hz.stallD    = 1'b0;
    hz.stallE    = 1'b0;
    hz.stallM    = 1'b0;
    hz.flushD    = 1'b0;
    hz.flushE    = 1'b0;
    hz.flushW    = 1'b0;
    hz.mem_req   = 1'b0;
    if (rst) begin
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushW = 1'b1;
    end else begin
      if (hz.regWriteM && (hz.WA3M == hz.RA1E)) begin
        hz.forwardAE = 2'b10;
      end else if (hz.regWriteW && (hz.WA3W == hz.RA1E)) begin
        hz.forwardAE = 2'b01;
      end else begin
        hz.forwardAE = 2'b00;
      end
      if (hz.regWriteM && (hz.WA3M == hz.RA2E)) begin
        hz.forwardBE = 2'b10;
      end else if (hz.regWriteW && (hz.WA3W == hz.RA2E)) begin
        hz.forwardBE = 2'b01;
      end else begin
        hz.forwardBE = 2'b00;
      end
      hz.mem_req = mem_op_s && (state_r != S_ERR);
      if (mem_stall_s) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.stallE = 1'b1;
        hz.stallM = 1'b1;
        hz.flushW = 1'b1;
      end else begin
        hz.stallF = ld_stall_s || pc_pend_s;
        hz.stallD = ld_stall_s;
        hz.flushE = ld_stall_s || hz.branchTakenE;
        hz.flushD = pc_pend_s || hz.PCSrcW || hz.branchTakenE;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run scored against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int MT = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  pipeline_hazard_ctrl_if #(.REG_AW(4)) hz ();

  pipeline_hazard_ctrl #(.REG_AW(4), .MEM_TIMEOUT(MT)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    hz.RA1D = 4'd0; hz.RA2D = 4'd0; hz.RA1E = 4'd0; hz.RA2E = 4'd0;
    hz.WA3E = 4'd0; hz.WA3M = 4'd0; hz.WA3W = 4'd0;
    hz.regWriteE = 1'b0; hz.regWriteM = 1'b0; hz.regWriteW = 1'b0;
    hz.memToRegE = 1'b0; hz.memWriteM = 1'b0; hz.memToRegM = 1'b0;
    hz.PCSrcD = 1'b0; hz.PCSrcE = 1'b0; hz.PCSrcM = 1'b0; hz.PCSrcW = 1'b0;
    hz.branchTakenE = 1'b0; hz.mem_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    hz.regWriteM = 1'b1; hz.WA3M = 4'd2; hz.RA1E = 4'd2; hz.RA2E = 4'd2;
    hz.memWriteM = 1'b1; hz.memToRegE = 1'b1; hz.PCSrcD = 1'b1;
    #1;
    checks++;
    if ({hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushW,
         hz.forwardAE, hz.forwardBE, hz.mem_req} !== 12'b0000_111_0000_0) begin
      errors++;
      $display("FAIL reset_outputs got st=%b%b%b%b fl=%b%b%b fw=%b/%b req=%b exp stalls 0 flushes 111 fwd 00 req 0",
               hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushD, hz.flushE, hz.flushW,
               hz.forwardAE, hz.forwardBE, hz.mem_req);
    end
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if ({hz.mem_err, hz.mem_req, hz.stallM, hz.flushW} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release got err=%b req=%b stallM=%b flushW=%b exp 0000",
               hz.mem_err, hz.mem_req, hz.stallM, hz.flushW);
    end
  endtask

  task automatic test_forwarding();
    do_reset();
    hz.regWriteM = 1'b1; hz.WA3M = 4'd3; hz.RA1E = 4'd3;
    hz.regWriteW = 1'b1; hz.WA3W = 4'd3; hz.RA2E = 4'd7;
    #1;
    checks++;
    if (hz.forwardAE !== 2'b10 || hz.forwardBE !== 2'b00) begin
      errors++;
      $display("FAIL fwd_m_priority got A=%b B=%b exp A=10 B=00", hz.forwardAE, hz.forwardBE);
    end
    hz.regWriteM = 1'b0;
    #1;
    checks++;
    if (hz.forwardAE !== 2'b01) begin
      errors++;
      $display("FAIL fwd_w got %b exp 01", hz.forwardAE);
    end
    hz.RA2E = 4'd0; hz.WA3M = 4'd0; hz.regWriteM = 1'b1; hz.RA1E = 4'd9;
    #1;
    checks++;
    if (hz.forwardAE !== 2'b00 || hz.forwardBE !== 2'b10) begin
      errors++;
      $display("FAIL fwd_reg0 got A=%b B=%b exp A=00 B=10", hz.forwardAE, hz.forwardBE);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    hz.memToRegE = 1'b1; hz.WA3E = 4'd5; hz.RA2D = 4'd5; hz.RA1D = 4'd1;
    #1;
    checks++;
    if ({hz.stallF, hz.stallD, hz.stallE, hz.flushE, hz.flushD} !== 5'b11010) begin
      errors++;
      $display("FAIL load_use got sF=%b sD=%b sE=%b fE=%b fD=%b exp 1 1 0 1 0",
               hz.stallF, hz.stallD, hz.stallE, hz.flushE, hz.flushD);
    end
    tick();
    hz.memToRegE = 1'b0;
    #1;
    checks++;
    if ({hz.stallF, hz.stallD, hz.flushE} !== 3'b000) begin
      errors++;
      $display("FAIL load_use_clear got sF=%b sD=%b fE=%b exp 000", hz.stallF, hz.stallD, hz.flushE);
    end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    hz.memToRegM = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if ({hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushW, hz.flushD, hz.flushE, hz.mem_req} !== 8'b11111001) begin
        errors++;
        $display("FAIL mem_wait_stall[%0d] got st=%b%b%b%b fW=%b fD=%b fE=%b req=%b exp 1111 1 0 0 1",
                 c, hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushW, hz.flushD, hz.flushE, hz.mem_req);
      end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    checks++;
    if ({hz.stallF, hz.stallM, hz.flushW, hz.mem_req} !== 4'b0001) begin
      errors++;
      $display("FAIL mem_wait_release got sF=%b sM=%b fW=%b req=%b exp 0 0 0 1",
               hz.stallF, hz.stallM, hz.flushW, hz.mem_req);
    end
    tick();
    // back in IDLE: a same-cycle completion must not stall at all
    #1;
    checks++;
    if ({hz.stallM, hz.mem_err} !== 2'b00) begin
      errors++;
      $display("FAIL mem_zero_stall got sM=%b err=%b exp 00", hz.stallM, hz.mem_err);
    end
    tick();
    // boundary: ready arrives on the last allowed WAIT cycle
    hz.mem_ready = 1'b0;
    for (int c = 0; c < MT - 1; c++) tick();
    hz.mem_ready = 1'b1;
    tick();
    hz.memToRegM = 1'b0;
    #1;
    checks++;
    if ({hz.mem_err, hz.stallM} !== 2'b00) begin
      errors++;
      $display("FAIL mem_last_cycle_ok got err=%b sM=%b exp 00", hz.mem_err, hz.stallM);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    hz.memWriteM = 1'b1;
    for (int c = 0; c < MT; c++) begin
      #1;
      checks++;
      if ({hz.stallF, hz.stallM, hz.mem_err} !== 3'b110) begin
        errors++;
        $display("FAIL timeout_pre[%0d] got sF=%b sM=%b err=%b exp 1 1 0", c, hz.stallF, hz.stallM, hz.mem_err);
      end
      tick();
    end
    hz.memWriteM = 1'b0;
    #1;
    checks++;
    if ({hz.mem_err, hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushW, hz.mem_req} !== 7'b1111110) begin
      errors++;
      $display("FAIL timeout_err got err=%b st=%b%b%b%b fW=%b req=%b exp 1 1111 1 0",
               hz.mem_err, hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.flushW, hz.mem_req);
    end
    tick();
    tick();
    checks++;
    if (hz.mem_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_sticky got %b exp 1", hz.mem_err);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({hz.flushD, hz.flushE, hz.flushW, hz.stallF, hz.stallM} !== 5'b11100) begin
      errors++;
      $display("FAIL timeout_rst got fD=%b fE=%b fW=%b sF=%b sM=%b exp 11100",
               hz.flushD, hz.flushE, hz.flushW, hz.stallF, hz.stallM);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({hz.mem_err, hz.stallM} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_cleared got err=%b sM=%b exp 00", hz.mem_err, hz.stallM);
    end
  endtask

  task automatic test_branch_in_stall();
    do_reset();
    hz.memToRegM = 1'b1; hz.branchTakenE = 1'b1; hz.PCSrcE = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if ({hz.flushD, hz.flushE, hz.stallF} !== 3'b001) begin
        errors++;
        $display("FAIL branch_deferred[%0d] got fD=%b fE=%b sF=%b exp 0 0 1", c, hz.flushD, hz.flushE, hz.stallF);
      end
      tick();
    end
    hz.mem_ready = 1'b1;
    #1;
    checks++;
    if ({hz.flushD, hz.flushE, hz.stallF, hz.stallM} !== 4'b1110) begin
      errors++;
      $display("FAIL branch_released got fD=%b fE=%b sF=%b sM=%b exp 1 1 1 0",
               hz.flushD, hz.flushE, hz.stallF, hz.stallM);
    end
    tick();
  endtask

  task automatic test_rst_in_wait();
    do_reset();
    hz.memToRegM = 1'b1;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({hz.flushD, hz.flushE, hz.flushW, hz.mem_req} !== 4'b1110) begin
      errors++;
      $display("FAIL rst_wait_during got fD=%b fE=%b fW=%b req=%b exp 1110", hz.flushD, hz.flushE, hz.flushW, hz.mem_req);
    end
    tick();
    rst = 1'b0;
    hz.memToRegM = 1'b0;
    hz.mem_ready = 1'b0;
    #1;
    checks++;
    if ({hz.mem_err, hz.mem_req, hz.stallM} !== 3'b000) begin
      errors++;
      $display("FAIL rst_wait_after got err=%b req=%b sM=%b exp 000", hz.mem_err, hz.mem_req, hz.stallM);
    end
    tick();
  endtask

  // Randomized run against a model built from the timing rules: count
  // consecutive unanswered wait cycles of one access, error when the
  // budget of MEM_TIMEOUT-1 extra cycles runs out.
  task automatic test_random();
    int  waited = 0;
    bit  err    = 1'b0;
    logic [12:0] got, exp;
    logic [1:0]  fa, fb;
    bit mem_op, mstall, ld, pcp;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      hz.RA1D = 4'($urandom_range(0, 3)); hz.RA2D = 4'($urandom_range(0, 3));
      hz.RA1E = 4'($urandom_range(0, 3)); hz.RA2E = 4'($urandom_range(0, 3));
      hz.WA3E = 4'($urandom_range(0, 3)); hz.WA3M = 4'($urandom_range(0, 3));
      hz.WA3W = 4'($urandom_range(0, 3));
      hz.regWriteE = 1'($urandom); hz.regWriteM = 1'($urandom); hz.regWriteW = 1'($urandom);
      hz.memToRegE = ($urandom_range(0, 3) == 0);
      hz.memWriteM = ($urandom_range(0, 3) == 0);
      hz.memToRegM = ($urandom_range(0, 3) == 0);
      hz.PCSrcD = ($urandom_range(0, 7) == 0); hz.PCSrcE = ($urandom_range(0, 7) == 0);
      hz.PCSrcM = ($urandom_range(0, 7) == 0); hz.PCSrcW = ($urandom_range(0, 7) == 0);
      hz.branchTakenE = ($urandom_range(0, 7) == 0);
      hz.mem_ready = ($urandom_range(0, 2) == 0);
      #1;
      mem_op = hz.memWriteM || hz.memToRegM;
      mstall = err || (mem_op && !hz.mem_ready);
      ld     = hz.memToRegE && (hz.WA3E == hz.RA1D || hz.WA3E == hz.RA2D);
      pcp    = hz.PCSrcD || hz.PCSrcE || hz.PCSrcM;
      fa = (hz.regWriteM && hz.WA3M == hz.RA1E) ? 2'd2 : (hz.regWriteW && hz.WA3W == hz.RA1E) ? 2'd1 : 2'd0;
      fb = (hz.regWriteM && hz.WA3M == hz.RA2E) ? 2'd2 : (hz.regWriteW && hz.WA3W == hz.RA2E) ? 2'd1 : 2'd0;
      if (rst)
        exp = {2'd0, 2'd0, 4'b0000, 3'b111, 1'b0, err};
      else if (mstall)
        exp = {fa, fb, 4'b1111, 3'b001, mem_op && !err, err};
      else
        exp = {fa, fb, ld || pcp, ld, 2'b00, pcp || hz.PCSrcW || hz.branchTakenE,
               ld || hz.branchTakenE, 1'b0, mem_op, 1'b0};
      got = {hz.forwardAE, hz.forwardBE, hz.stallF, hz.stallD, hz.stallE, hz.stallM,
             hz.flushD, hz.flushE, hz.flushW, hz.mem_req, hz.mem_err};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random[%0d] got %b exp %b (fwA fwB sF sD sE sM fD fE fW req err)", n, got, exp);
      end
      if (rst) begin
        waited = 0; err = 1'b0;
      end else if (err) begin
        waited = waited;
      end else if (waited > 0) begin
        if (hz.mem_ready) waited = 0;
        else if (waited == MT - 1) err = 1'b1;
        else waited++;
      end else if (mem_op && !hz.mem_ready) begin
        waited = 1;
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_forwarding();
    test_load_use();
    test_mem_wait();
    test_timeout();
    test_branch_in_stall();
    test_rst_in_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
